uart_rx_os16: RTL
=================

# uart_rx_os16

Single-clock UART receiver with 16x oversampling and majority-vote bit detection. It replaces the derived-baud-clock receive path with one that runs entirely on the system clock. It accepts the same frame options as the transmitter (5–8 data bits, optional even/odd parity, 1 or 2 stop bits) and reports parity and framing errors. It sits between the serial line pin and the host-side receive logic, and pairs with the existing transmitter for loopback.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the `rx` input synchronizer; minimum 2.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `rx_start` input 1: receive enable; sampled only in IDLE.
- `rx` input 1: asynchronous serial line; idles high.
- `baud` input 17: `clk` cycles per 1/16-bit tick. 0 is treated as 1.
- `length` input 4: data bits. Values below 5 are treated as 5; values above 8 are treated as 8.
- `parity_en` input 1: a parity bit follows the data bits.
- `parity_type` input 1: 0 = even, 1 = odd.
- `stop2` input 1: two stop bits are expected.
- `rx_out` output 8: received data, right-justified, unused MSBs zero.
- `rx_done` output 1: one-`clk` pulse at frame completion.
- `rx_err` output 1: parity error of the last frame.
- `frame_err` output 1: a stop bit of the last frame was sampled low.
- `busy` output 1: high in every state except IDLE.

## Operation
- Synchronizer flops reset to 1. All further logic uses the synchronized `rx_s`.
- Tick generator: counts `clk` cycles and emits a 1-cycle `tick` every `baud` cycles. It is held in reset while in IDLE and restarts at 0 on start detection.
- `baud`, `length`, `parity_en`, `parity_type` and `stop2` are latched on start detection. Changes during a frame take effect on the next frame.
- Bit sampling: a 4-bit tick counter runs per bit. `rx_s` is sampled at ticks 7, 8 and 9, and the bit value is the majority of the three samples. The bit ends at tick 15.
- States:
  - IDLE: if `rx_start`=1 and `rx_s`=0, latch configuration and go to START.
  - START: at the majority decision, a result of 1 is a false start and returns to IDLE with no flags and no `rx_done`. A result of 0 goes to DATA at the end of the bit.
  - DATA: receive N bits LSB-first into a shift register. Go to PARITY if `parity_en`, else STOP1.
  - PARITY: expected parity = XOR of the data bits XOR `parity_type`. Record the mismatch, then go to STOP1.
  - STOP1: at the majority decision, if `stop2`=0 go to DONE immediately (mid-bit); otherwise continue to the end of the bit and go to STOP2.
  - STOP2: at the majority decision, go to DONE.
  - DONE: one cycle. Update `rx_out`, `rx_err` and `frame_err`, and pulse `rx_done`. If any stop bit was 0, go to WAIT_HIGH; else go to IDLE.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering a frame.
- `rx_start` deassertion mid-frame has no effect; the frame completes.
- `rx_out`, `rx_err` and `frame_err` hold their values until the next DONE. Both flags are valid together with `rx_done`.
- Asynchronous reset mid-frame: return to IDLE immediately. The partial frame is discarded with no `rx_done`.

## Timing
- Reset values: `rx_out`=0, `rx_done`=0, `rx_err`=0, `frame_err`=0, `busy`=0.
- Start detection: in the cycle `rx_s` first reads 0 in IDLE. `busy` rises the next cycle.
- Tick latency: `tick` fires `baud` cycles after restart, and every `baud` cycles thereafter.
- `rx_done` latency: `rx_done` is high exactly one `clk` after the tick-9 sample of the last stop bit.
- Back-to-back frames: the receiver returns to IDLE about 6 ticks before the nominal end of the stop bit, so consecutive frames are accepted.
- Input latency: the `rx` to `rx_s` latency of `SYNC_STAGES` cycles is absorbed by the ±1-tick sample window.

## Structure
- Package `uart_pkg` holds:
  - the state enum `rx_state_t`;
  - `OS_RATE`=16;
  - `SAMPLE_LO`=7, `SAMPLE_MID`=8, `SAMPLE_HI`=9;
  - `MIN_LEN`=5, `MAX_LEN`=8.
- Sub-module `uart_baud_tick`: the 17-bit divider with a synchronous clear input and a `tick` output.

## Test plan
- Nominal frame: `baud`=4, 8N1, byte 0xA5 → `rx_done` pulse with `rx_out`=0xA5, `rx_err`=0, `frame_err`=0; `busy` low after the pulse.
- 5-bit odd parity, 2 stop bits: `length`=5, `parity_en`=1, `parity_type`=1, data 0x13 with correct parity → `rx_out`=0x13; repeat with the parity bit flipped → `rx_err`=1, `rx_out`=0x13.
- False start: a low glitch on `rx` shorter than 6 ticks → no `rx_done`, `busy` returns to 0, flags unchanged.
- Framing error and break: stop bit driven 0, then `rx` held low for 3 bit-times → one `rx_done` with `frame_err`=1, no second frame until `rx` goes high.
- Back-to-back and loopback: drive the transmitter output into `rx` with 0x00, 0xFF, 0x5A sent consecutively, with ±3% baud skew → three `rx_done` pulses with matching bytes.
- Reset mid-frame: assert `rst`=0 during DATA → all outputs are 0 immediately; after release, the next frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_os16_pkg.sv
// Shared types and constants for the 16x oversampling UART receiver.
// Holds the receive state encoding, sample-window positions and frame-length limits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE,
        WAIT_HIGH
    } rx_state_t;

    localparam int         OS_RATE    = 16;
    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;
    localparam logic [3:0] MIN_LEN    = 4'd5;
    localparam logic [3:0] MAX_LEN    = 4'd8;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < MIN_LEN) return MIN_LEN;
        if (len > MAX_LEN) return MAX_LEN;
        return len;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Host-side bundle of the UART receiver: line input, frame configuration and results.
// The master side drives the line and configuration; the receiver is the slave.
interface uart_rx_os16_if;
    logic        rx_start;
    logic        rx;
    logic [16:0] baud;
    logic [3:0]  length;
    logic        parity_en;
    logic        parity_type;
    logic        stop2;
    logic [7:0]  rx_out;
    logic        rx_done;
    logic        rx_err;
    logic        frame_err;
    logic        busy;

    modport master (
        output rx_start, rx, baud, length, parity_en, parity_type, stop2,
        input  rx_out, rx_done, rx_err, frame_err, busy
    );

    modport slave (
        input  rx_start, rx, baud, length, parity_en, parity_type, stop2,
        output rx_out, rx_done, rx_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_os16_baud_tick.sv
// Oversampling tick divider: one-cycle tick every div_i clocks (0 behaves as 1).
// Held at zero while clr_i is high so the first tick lands div_i cycles after release.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic [16:0] div_i,
    output logic        tick_o
);
    logic [16:0] cnt_q, cnt_d;
    logic [16:0] div_eff;

    assign div_eff = (div_i == 17'd0) ? 17'd1 : div_i;
    assign tick_o  = !clr_i && (cnt_q == div_eff - 17'd1);

    always_comb begin
        cnt_d = cnt_q + 17'd1;
        if (clr_i || tick_o) cnt_d = 17'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 17'd0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_os16.sv
// Single-clock UART receiver, 16x oversampled with a 3-sample majority vote per bit.
// Supports 5-8 data bits, optional even/odd parity, 1 or 2 stop bits; flags parity/framing errors.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_os16_if.slave bus
);
    localparam logic [3:0] BIT_END = 4'(OS_RATE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_t              state_q;
    logic [3:0]             os_q;
    logic [2:0]             bit_q;
    logic                   par_err_q, stop_err_q;
    logic                   busy_q, rx_done_q, rx_err_q, frame_err_q;
    logic [7:0]             rx_out_q;
    logic [16:0]            baud_q;
    logic [3:0]             len_q;
    logic                   pen_q, ptype_q, stop2_q;
    logic [1:0]             smp_q;
    logic [7:0]             sreg_q;
    logic                   tick, start_det, mid_tick, end_tick, bit_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign start_det = (state_q == IDLE) && bus.rx_start && !rx_s;
    assign mid_tick  = tick && (os_q == SAMPLE_HI);
    assign end_tick  = tick && (os_q == BIT_END);
    assign bit_val   = maj3(smp_q[0], smp_q[1], rx_s);

    uart_baud_tick u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE),
        .div_i  (baud_q),
        .tick_o (tick)
    );

    // Configuration is frozen at start detection so mid-frame changes apply to the next frame.
    always_ff @(posedge clk) begin
        if (start_det) begin
            baud_q  <= bus.baud;
            len_q   <= clamp_len(bus.length);
            pen_q   <= bus.parity_en;
            ptype_q <= bus.parity_type;
            stop2_q <= bus.stop2;
            sreg_q  <= '0;
        end else if (tick) begin
            if (os_q == SAMPLE_LO)  smp_q[0] <= rx_s;
            if (os_q == SAMPLE_MID) smp_q[1] <= rx_s;
            if (os_q == SAMPLE_HI && state_q == DATA) sreg_q[bit_q] <= bit_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            os_q        <= 4'd0;
            bit_q       <= 3'd0;
            par_err_q   <= 1'b0;
            stop_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_out_q    <= 8'd0;
            rx_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            if (tick) os_q <= os_q + 4'd1;
            case (state_q)
                IDLE: begin
                    if (start_det) begin
                        state_q    <= START;
                        busy_q     <= 1'b1;
                        os_q       <= 4'd0;
                        bit_q      <= 3'd0;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (mid_tick && bit_val) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (end_tick) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (end_tick) begin
                        bit_q <= bit_q + 3'd1;
                        if ({1'b0, bit_q} == len_q - 4'd1) state_q <= pen_q ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (mid_tick)      par_err_q <= bit_val != ((^sreg_q) ^ ptype_q);
                    else if (end_tick) state_q   <= STOP1;
                end
                // With one stop bit the frame completes mid-bit, leaving margin for back-to-back frames.
                STOP1: begin
                    if (mid_tick) begin
                        stop_err_q <= !bit_val;
                        if (!stop2_q) begin
                            state_q     <= DONE;
                            rx_done_q   <= 1'b1;
                            rx_out_q    <= sreg_q;
                            rx_err_q    <= par_err_q;
                            frame_err_q <= !bit_val;
                        end
                    end else if (end_tick) begin
                        state_q <= STOP2;
                    end
                end
                STOP2: begin
                    if (mid_tick) begin
                        state_q     <= DONE;
                        rx_done_q   <= 1'b1;
                        rx_out_q    <= sreg_q;
                        rx_err_q    <= par_err_q;
                        frame_err_q <= stop_err_q | !bit_val;
                    end
                end
                DONE: begin
                    state_q <= frame_err_q ? WAIT_HIGH : IDLE;
                    busy_q  <= frame_err_q;
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_out    = rx_out_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.rx_err    = rx_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule
